// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM PIO port: register map, edge-type codes
// and bus width.
package pio_pkg;

    localparam int BUS_W = 32;

    typedef enum logic [2:0] {
        ADDR_DATA    = 3'd0,
        ADDR_DIR     = 3'd1,
        ADDR_IRQMASK = 3'd2,
        ADDR_EDGECAP = 3'd3,
        ADDR_OUTSET  = 3'd4,
        ADDR_OUTCLR  = 3'd5
    } pio_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_edge_detect.sv
// Two-flop synchronizer per input bit plus a third flop for edge detection.
// EDGE_TYPE selects rising, falling or any edge.
module pio_edge_detect
    import pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync_in = s2;

    generate
        if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign edge_pulse = ~s2 & s3;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_pulse = s2 ^ s3;
        end else begin : g_rise
            assign edge_pulse = s2 & ~s3;
        end
    endgenerate

endmodule

// File: rtl/pio_lcd_port.sv
// Parametrised Avalon-MM GPIO port with direction, edge capture and level IRQ.
// Define PIO_BIT_SET_CLR_EN to enable the outset (4) / outclear (5) registers.
module pio_lcd_port
    import pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_out, direction, irqmask, edgecapture;
    logic [WIDTH-1:0] sync_in, edge_pulse, wd, cap_clr;
    logic [WIDTH-1:0] rd;
    logic             wr;
    logic             unused_wdata;

    pio_edge_detect #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .sync_in    (sync_in),
        .edge_pulse (edge_pulse)
    );

    assign wr           = chipselect & ~write_n;
    assign wd           = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign cap_clr      = (wr && address == ADDR_EDGECAP) ? wd : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out    <= RESET_VALUE;
            direction   <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr) begin
                case (address)
                    ADDR_DATA:    data_out  <= wd;
                    ADDR_DIR:     direction <= wd;
                    ADDR_IRQMASK: irqmask   <= wd;
`ifdef PIO_BIT_SET_CLR_EN
                    ADDR_OUTSET:  data_out  <= data_out | wd;
                    ADDR_OUTCLR:  data_out  <= data_out & ~wd;
`endif
                    default:      ;
                endcase
            end
            // A fresh edge overrides a simultaneous write-1-to-clear.
            edgecapture <= (edgecapture & ~cap_clr) | edge_pulse;
            irq         <= |(edgecapture & irqmask);
        end
    end

    always_comb begin
        rd = '0;
        case (address)
            ADDR_DATA:    rd = sync_in;
            ADDR_DIR:     rd = direction;
            ADDR_IRQMASK: rd = irqmask;
            ADDR_EDGECAP: rd = edgecapture;
            default:      rd = '0;
        endcase
    end

    assign readdata = BUS_W'(rd);
    assign out_port = data_out;
    assign oe_port  = direction;

endmodule
